cam_capture: RTL and testbench
==============================

# cam_capture

Camera capture front end: registers the sensor's raw pixel bus and frame/line valid strobes, gates whole frames under software start/stop control, and produces per-pixel horizontal/vertical coordinates plus frame statistics. The `h_cont` output feeds the Avalon PIO that exposes the horizontal count to the Nios II. `v_cont` and `frame_cont` feed sibling PIOs. `pix_data` and `pix_valid` feed the downstream pixel pipeline.

## Interface
- `DATA_W`, 12: sensor pixel width
- `H_W`, 16: horizontal count width
- `V_W`, 16: vertical count width
- `FRAME_W`, 32: frame counter width

- `clk`  in  1  sensor pixel clock; sole clock; all inputs synchronous to it
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: arm capture
- `stop`  in  1  one-cycle pulse: end capture
- `cam_data`  in  DATA_W  raw pixel
- `cam_fval`  in  1  frame valid
- `cam_lval`  in  1  line valid
- `pix_data`  out  DATA_W  captured pixel
- `pix_valid`  out  1  `pix_data`, `h_cont`, `v_cont` valid this cycle
- `h_cont`  out  H_W  0-based pixel index within line
- `v_cont`  out  V_W  0-based line index within frame
- `frame_cont`  out  FRAME_W  completed captured frames
- `line_len`  out  H_W  pixel count of last completed line
- `frame_lines`  out  V_W  line count of last completed frame
- `capturing`  out  1  high in ARMED, CAPTURE or DRAIN

Reset: all outputs 0, state IDLE, all internal counters 0.

## Operation
- **Stage 1:** register `cam_data`, `cam_fval`, `cam_lval` into `data_d`, `fval_d`, `lval_d`. Keep previous `fval_d`/`lval_d` for edge detection.
- **Active pixel:** `fval_d & lval_d` while in CAPTURE or DRAIN, and only when the current frame began in CAPTURE (`in_frame` flag).
- **FSM:**
  - IDLE: `start` → ARMED.
  - ARMED: `stop` → IDLE. Rising edge of `fval_d` → CAPTURE and set `in_frame`. A frame already in progress when ARMED is entered is ignored.
  - CAPTURE: falling edge of `fval_d` ends the frame and stays in CAPTURE, so the next rising edge starts a new frame. `stop` → DRAIN if `in_frame`, else IDLE.
  - DRAIN: falling edge of `fval_d` ends the frame → IDLE.
  - `start` outside IDLE is ignored. `start` and `stop` in the same cycle: `stop` wins; from IDLE, stay in IDLE.
- **h counter:** increments per active pixel and saturates at 2^H_W−1; no wrap.
- **Line end:** falling edge of `lval_d` with `in_frame`, including the cycle `fval_d` falls with `lval` high (truncated line). Actions: `line_len` ← h count, h count ← 0, line count += 1 (saturating).
- **Frame end:** falling edge of `fval_d` with `in_frame`. Actions: `frame_lines` ← line count, including a line ending the same cycle; line count ← 0; `frame_cont` += 1 (wraps); clear `in_frame`.
- **Zero-length frame:** `fval` high with no `lval` still counts as a frame, with `frame_lines` = 0.
- **Stage 2:** register `pix_valid`, `pix_data`, `h_cont`, `v_cont`. `h_cont`/`v_cont` hold the values before that pixel's increment. When `pix_valid` is 0, `pix_data`, `h_cont` and `v_cont` hold their last values.
- **Reset mid-frame:** everything returns to IDLE/0 immediately. After release, no capture until `start` plus a fresh `fval` rising edge.

## Timing
- `cam_*` sampled at edge N → `pix_valid`/`pix_data`/`h_cont`/`v_cont` at edge N+2. Fixed 2-cycle latency.
- `cam_lval` falls at edge N → `line_len` updates at N+2.
- `cam_fval` falls at edge N → `frame_lines`, `frame_cont` update at N+2.
- `start` at edge N → `capturing` = 1 at N+1. `stop` in ARMED at edge N → `capturing` = 0 at N+1.
- Back-to-back lines with one blanking cycle are supported. Lines with zero blanking are merged into one line; this is documented as undefined sensor behaviour.

## Structure
- Package `cam_capture_pkg`:
  - state enum `{IDLE, ARMED, CAPTURE, DRAIN}`
  - default width localparams
  - edge-type helper constants
- Sub-module `cam_edge_det`: registers a 1-bit strobe and emits rise/fall pulses; instantiated for `fval` and `lval`.
- Top level holds the FSM, counters and stage-2 output registers.

## Test plan
- **Basic frame:** `start`, then frame of 3 lines × 4 pixels with 2-cycle blanking.
  - `h_cont` 0..3 ×3, `v_cont` 0,1,2.
  - `line_len` = 4, `frame_lines` = 3, `frame_cont` = 1.
  - `pix_data` equals input delayed 2 cycles.
- **Mid-frame start:** `start` asserted during line 1 of a frame → no `pix_valid` for that frame. Next frame captured with `v_cont` starting at 0.
- **Stop in CAPTURE:** `stop` during line 1 of a 3-line frame → frame completes, `frame_cont` += 1, then IDLE. Next frame yields no `pix_valid`.
- **Truncated line:** `fval` and `lval` fall together after 2 pixels of line 2 → `line_len` = 2, `frame_lines` = 3.
- **Start/stop collision:** `start` and `stop` in the same cycle from IDLE → `capturing` stays 0. `stop` in ARMED → IDLE in 1 cycle.
- **Reset mid-line:** assert `reset_n` low mid-line → all outputs 0 at once. Release with `fval` high → no capture until `start` plus a new `fval` rise.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Camera capture shared types and constants.
// States, default widths and strobe edge helpers.
package cam_capture_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int H_W_DEF     = 16;
  localparam int V_W_DEF     = 16;
  localparam int FRAME_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } cam_state_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_N    = 2;

  function automatic logic [EDGE_N-1:0] edge_of(
    input logic cur,
    input logic prev
  );
    logic [EDGE_N-1:0] e;
    e = '0;
    e[EDGE_RISE] = cur & ~prev;
    e[EDGE_FALL] = prev & ~cur;
    return e;
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registers a 1-bit sensor strobe and flags
// its rising/falling edges against the previous sample.
module cam_edge_det
  import cam_capture_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              strobe,
  output logic              q,
  output logic [EDGE_N-1:0] edges
);

  logic q_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      q      <= strobe;
      q_prev <= q;
    end
  end

  assign edges = edge_of(q, q_prev);

endmodule

// File: rtl/cam_capture.sv
// Camera capture front end: frame gating FSM,
// pixel coordinates and per-frame statistics.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int H_W     = H_W_DEF,
  parameter int V_W     = V_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DATA_W-1:0]  cam_data,
  input  logic               cam_fval,
  input  logic               cam_lval,
  output logic [DATA_W-1:0]  pix_data,
  output logic               pix_valid,
  output logic [H_W-1:0]     h_cont,
  output logic [V_W-1:0]     v_cont,
  output logic [FRAME_W-1:0] frame_cont,
  output logic [H_W-1:0]     line_len,
  output logic [V_W-1:0]     frame_lines,
  output logic               capturing
);

  logic [DATA_W-1:0] data_d;
  logic              fval_d;
  logic              lval_d;
  logic [EDGE_N-1:0] fval_e;
  logic [EDGE_N-1:0] lval_e;

  cam_edge_det u_fval (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (cam_fval),
    .q       (fval_d),
    .edges   (fval_e)
  );

  cam_edge_det u_lval (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (cam_lval),
    .q       (lval_d),
    .edges   (lval_e)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_d <= '0;
    else          data_d <= cam_data;
  end

  cam_state_e state;
  cam_state_e state_nxt;
  logic       in_frame;
  logic       in_frame_nxt;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [V_W-1:0] v_total;

  logic fval_rise;
  logic fval_fall;
  logic frame_end;
  logic line_end;
  logic active;
  logic unused_lval_rise;

  assign fval_rise = fval_e[EDGE_RISE];
  assign fval_fall = fval_e[EDGE_FALL];
  assign unused_lval_rise = lval_e[EDGE_RISE];

  assign frame_end = in_frame & fval_fall;
  // a frame dropping with lval still high truncates the line
  assign line_end  = in_frame &
                     (lval_e[EDGE_FALL] | (fval_fall & lval_d));
  assign active    = fval_d & lval_d & in_frame &
                     ((state == CAPTURE) | (state == DRAIN));

  always_comb begin
    state_nxt    = state;
    in_frame_nxt = in_frame & ~frame_end;
    unique case (state)
      IDLE: begin
        if (start & ~stop) state_nxt = ARMED;
      end
      ARMED: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (fval_rise) begin
          state_nxt    = CAPTURE;
          in_frame_nxt = 1'b1;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_nxt = (in_frame & ~frame_end) ? DRAIN : IDLE;
        end else if (fval_rise) begin
          in_frame_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      in_frame <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_frame <= in_frame_nxt;
    end
  end

  assign capturing = (state != IDLE);

  // lines closing on the frame edge still count
  assign v_total = (line_end && v_cnt != '1) ? v_cnt + 1'b1 : v_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_cont  <= '0;
    end else begin
      if (line_end) begin
        h_cnt    <= '0;
        line_len <= h_cnt;
      end else if (active && h_cnt != '1) begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (frame_end) begin
        v_cnt       <= '0;
        frame_lines <= v_total;
        frame_cont  <= frame_cont + 1'b1;
      end else begin
        v_cnt <= v_total;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      h_cont    <= '0;
      v_cont    <= '0;
    end else begin
      pix_valid <= active;
      if (active) begin
        pix_data <= data_d;
        h_cont   <= h_cnt;
        v_cont   <= v_cnt;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: per-cycle vector
// tables for frames plus hand sequences for control corners.
module tb_cam_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [11:0] cam_data;
  logic        cam_fval;
  logic        cam_lval;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic [15:0] h_cont;
  logic [15:0] v_cont;
  logic [31:0] frame_cont;
  logic [15:0] line_len;
  logic [15:0] frame_lines;
  logic        capturing;

  cam_capture dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .cam_data    (cam_data),
    .cam_fval    (cam_fval),
    .cam_lval    (cam_lval),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .h_cont      (h_cont),
    .v_cont      (v_cont),
    .frame_cont  (frame_cont),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .capturing   (capturing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        fv;
    logic        lv;
    logic [11:0] d;
    logic        px;
    logic [15:0] h;
    logic [15:0] v;
  } vec_t;

  vec_t tbl[$];
  int   seq = 32'h5a0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic st, input logic sp,
                               input logic fv, input logic lv,
                               input logic px,
                               input int h, input int v);
    vec_t r;
    r.st = st;
    r.sp = sp;
    r.fv = fv;
    r.lv = lv;
    r.d  = seq[11:0];
    r.px = px;
    r.h  = h[15:0];
    r.v  = v[15:0];
    seq  = seq + 37;
    tbl.push_back(r);
  endfunction

  // rise, lines of pix pixels with 2 blanking cycles, then fall
  task automatic build_frame(input int lines, input int pix,
                             input int last_pix, input bit trunc,
                             input bit cap, input int start_line,
                             input int stop_line);
    push(0, 0, 1, 0, 0, 0, 0);
    for (int l = 0; l < lines; l++) begin
      int np;
      np = (l == lines - 1) ? last_pix : pix;
      for (int p = 0; p < np; p++)
        push(l == start_line && p == 0, l == stop_line && p == 0,
             1, 1, cap, p, l);
      if (!(trunc && l == lines - 1)) begin
        push(0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 1, 0, 0, 0, 0);
      end
    end
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(input vec_t r);
    start    = r.st;
    stop     = r.sp;
    cam_fval = r.fv;
    cam_lval = r.lv;
    cam_data = r.d;
  endtask

  task automatic check_row(input vec_t r);
    chk("pix_valid", {31'd0, pix_valid}, {31'd0, r.px});
    if (r.px) begin
      chk("h_cont", {16'd0, h_cont}, {16'd0, r.h});
      chk("v_cont", {16'd0, v_cont}, {16'd0, r.v});
      chk("pix_data", {20'd0, pix_data}, {20'd0, r.d});
    end
  endtask

  task automatic run_tbl(input bit flush);
    vec_t idle;
    idle = '{default: '0};
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
      if (i > 0) check_row(tbl[i-1]);
    end
    if (flush && tbl.size() > 0) begin
      drive(idle);
      tick();
      check_row(tbl[tbl.size()-1]);
    end
    tbl.delete();
  endtask

  task automatic stats(input string tag, input int fc,
                       input int fl, input int ll, input logic cap);
    chk({tag, ".frame_cont"}, frame_cont, fc);
    chk({tag, ".frame_lines"}, {16'd0, frame_lines}, fl);
    chk({tag, ".line_len"}, {16'd0, line_len}, ll);
    chk({tag, ".capturing"}, {31'd0, capturing}, {31'd0, cap});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".pix_valid"}, {31'd0, pix_valid}, 0);
    chk({tag, ".pix_data"}, {20'd0, pix_data}, 0);
    chk({tag, ".h_cont"}, {16'd0, h_cont}, 0);
    chk({tag, ".v_cont"}, {16'd0, v_cont}, 0);
    stats(tag, 0, 0, 0, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    cam_data = '0;
    cam_fval = 1'b0;
    cam_lval = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // basic 3x4 frame
    push(1, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    build_frame(3, 4, 4, 0, 1, -1, -1);
    run_tbl(1);
    stats("basic", 1, 3, 4, 1'b1);

    // third line cut after 2 pixels by fval
    build_frame(3, 4, 2, 1, 1, -1, -1);
    run_tbl(1);
    stats("trunc", 2, 3, 2, 1'b1);

    // stop during line 1 drains the frame, then idle
    build_frame(3, 4, 4, 0, 1, -1, 1);
    run_tbl(1);
    stats("stop", 3, 3, 4, 1'b0);
    build_frame(2, 3, 3, 0, 0, -1, -1);
    run_tbl(1);
    stats("after_stop", 3, 3, 4, 1'b0);

    // start mid-frame: that frame dropped, next captured
    build_frame(3, 4, 4, 0, 0, 1, -1);
    build_frame(2, 3, 3, 0, 1, -1, -1);
    run_tbl(1);
    stats("midstart", 4, 2, 3, 1'b1);

    // zero-length frame
    build_frame(0, 0, 0, 0, 1, -1, -1);
    run_tbl(1);
    stats("zero", 5, 0, 3, 1'b1);

    // control pulses
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_capture.capturing", {31'd0, capturing}, 0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("collide.capturing", {31'd0, capturing}, 0);
    tick();
    chk("collide2.capturing", {31'd0, capturing}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm.capturing", {31'd0, capturing}, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("disarm.capturing", {31'd0, capturing}, 0);

    // reset in the middle of a captured line
    push(1, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) push(0, 0, 1, 1, 1, p, 0);
    run_tbl(0);
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cam_fval = 1'b1;
      cam_lval = (i % 5) != 0;
      tick();
      chk("post_rst.pix_valid", {31'd0, pix_valid}, 0);
    end
    chk("post_rst.capturing", {31'd0, capturing}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rearm.capturing", {31'd0, capturing}, 1);
    for (int i = 0; i < 10; i++) begin
      cam_lval = (i % 4) != 0;
      tick();
      chk("no_rise.pix_valid", {31'd0, pix_valid}, 0);
    end
    cam_fval = 1'b0;
    cam_lval = 1'b0;
    tick();
    tick();
    chk("no_rise.frame_cont", frame_cont, 0);
    build_frame(1, 3, 3, 0, 1, -1, -1);
    run_tbl(1);
    stats("recover", 1, 1, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
